// File: rtl/gbar_if.sv
// Global barrier bus between the per-core warp schedulers and the cluster collector.
// Per-core request lanes are packed arrays indexed by core; the release response is broadcast.
interface gbar_if #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8,
    parameter int NB_WIDTH     = (NUM_BARRIERS > 2) ? $clog2(NUM_BARRIERS) : 1,
    parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
);
    logic [NUM_CORES-1:0]                req_valid;
    logic [NUM_CORES-1:0][NB_WIDTH-1:0]  req_id;
    logic [NUM_CORES-1:0][NC_WIDTH-1:0]  req_size_m1;
    logic [NUM_CORES-1:0]                req_ready;
    logic                                rsp_valid;
    logic [NB_WIDTH-1:0]                 rsp_id;
    logic                                busy;

    modport master (
        output req_valid, req_id, req_size_m1,
        input  req_ready, rsp_valid, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_id, req_size_m1,
        output req_ready, rsp_valid, rsp_id, busy
    );
endinterface

// File: rtl/gbar_collector.sv
// Cluster-level global barrier collector: round-robin accepts one core arrival per cycle,
// tracks an arrival mask per barrier id and broadcasts a one-cycle release pulse.
module gbar_collector #(
    parameter int NUM_CORES    = 4,
    parameter int NUM_BARRIERS = 8
) (
    input logic    clk,
    input logic    reset,
    gbar_if.slave  bus
);
    localparam int NB_WIDTH  = (NUM_BARRIERS > 2) ? $clog2(NUM_BARRIERS) : 1;
    localparam int NC_WIDTH  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CNT_WIDTH = $clog2(NUM_CORES + 1);

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [NUM_CORES-1:0] v);
        logic [CNT_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            n = n + CNT_WIDTH'(v[i]);
        end
        return n;
    endfunction

    logic [NC_WIDTH-1:0]                     r_rr_ptr;
    logic [NUM_BARRIERS-1:0][NUM_CORES-1:0]  r_mask;
    logic                                    r_rsp_valid;
    logic [NB_WIDTH-1:0]                     r_rsp_id;
    logic                                    r_busy;

    int                                      w_best_dist;
    int                                      w_dist;
    logic [NC_WIDTH-1:0]                     w_grant_idx;
    logic [NUM_CORES-1:0]                    w_grant;
    logic                                    w_fire;
    logic [NB_WIDTH-1:0]                     w_id;
    logic [NC_WIDTH-1:0]                     w_size;
    logic [NUM_CORES-1:0]                    w_new_mask;
    logic                                    w_release;
    logic [NUM_BARRIERS-1:0][NUM_CORES-1:0]  w_mask_nxt;

    // Round-robin grant: the valid core closest (cyclically) at or after r_rr_ptr wins.
    always_comb begin
        w_best_dist = NUM_CORES;
        w_dist      = 0;
        w_grant_idx = '0;
        w_grant     = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_dist = (c + NUM_CORES - int'(r_rr_ptr)) % NUM_CORES;
            if (bus.req_valid[c] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_grant_idx = NC_WIDTH'(c);
            end else begin
                w_best_dist = w_best_dist;
            end
        end
        w_fire = (w_best_dist < NUM_CORES) && !reset;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_grant[c] = w_fire && (w_grant_idx == NC_WIDTH'(c));
        end
    end

    // Arrival bookkeeping for the granted request; only the completing size_m1 matters.
    always_comb begin
        w_id   = '0;
        w_size = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (w_grant[c]) begin
                w_id   = bus.req_id[c];
                w_size = bus.req_size_m1[c];
            end else begin
                w_id   = w_id;
            end
        end
        w_new_mask = r_mask[w_id] | w_grant;
        w_release  = w_fire &&
                     (popcount(w_new_mask) == (CNT_WIDTH'(w_size) + CNT_WIDTH'(1'b1)));
        w_mask_nxt = r_mask;
        if (w_fire) begin
            w_mask_nxt[w_id] = w_release ? '0 : w_new_mask;
        end else begin
            w_mask_nxt = r_mask;
        end
    end

    // State and registered response/busy; busy mirrors the state being loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask      <= '0;
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_mask      <= w_mask_nxt;
            r_rsp_valid <= w_release;
            r_busy      <= (|w_mask_nxt) | w_release;
            if (w_fire) begin
                r_rr_ptr <= (w_grant_idx == NC_WIDTH'(NUM_CORES - 1)) ? '0
                                                                      : w_grant_idx + NC_WIDTH'(1);
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
            if (w_release) begin
                r_rsp_id <= w_id;
            end else begin
                r_rsp_id <= r_rsp_id;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_gbar_collector.sv
// Self-checking bench for gbar_collector: directed scenarios plus random traffic against
// a set-of-arrivals reference model; a second 3-core instance covers unreachable sizes.
module tb_gbar_collector;
    localparam int N = 4;
    localparam int B = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gbar_if #(.NUM_CORES(N), .NUM_BARRIERS(B)) bus ();
    gbar_collector #(.NUM_CORES(N), .NUM_BARRIERS(B)) dut (.clk(clk), .reset(reset), .bus(bus));

    gbar_if #(.NUM_CORES(3), .NUM_BARRIERS(4)) bus3 ();
    gbar_collector #(.NUM_CORES(3), .NUM_BARRIERS(4)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    int checks = 0;
    int failures = 0;

    // reference model: which cores have arrived at each barrier
    bit arrived [B][N];
    int m_rr;
    bit m_rsp_valid;
    int m_rsp_id;
    // pending requests held by each requester until accepted
    bit p_valid [N];
    int p_id [N];
    int p_size [N];
    int last_grant;
    int pulses;

    task automatic check_val(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int model_busy();
        int any;
        any = m_rsp_valid ? 1 : 0;
        for (int b = 0; b < B; b++)
            for (int c = 0; c < N; c++)
                if (arrived[b][c]) any = 1;
        return any;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < B; b++)
            for (int c = 0; c < N; c++) arrived[b][c] = 1'b0;
        for (int c = 0; c < N; c++) p_valid[c] = 1'b0;
        m_rr = 0;
        m_rsp_valid = 1'b0;
        m_rsp_id = 0;
    endtask

    task automatic cycle();
        int g;
        int cnt;
        int b;
        @(negedge clk);
        check_val("rsp_valid", bus.rsp_valid, int'(m_rsp_valid));
        check_val("rsp_id", bus.rsp_id, m_rsp_id);
        check_val("busy", bus.busy, model_busy());
        if (bus.rsp_valid === 1'b1) pulses++;
        for (int c = 0; c < N; c++) begin
            bus.req_valid[c]   = p_valid[c];
            bus.req_id[c]      = 3'(p_id[c]);
            bus.req_size_m1[c] = 2'(p_size[c]);
        end
        #1;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && p_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        check_val("req_ready", bus.req_ready, (g >= 0) ? (1 << g) : 0);
        @(posedge clk);
        last_grant = g;
        m_rsp_valid = 1'b0;
        if (g >= 0) begin
            b = p_id[g];
            arrived[b][g] = 1'b1;
            cnt = 0;
            for (int c = 0; c < N; c++) cnt += arrived[b][c];
            if (cnt == p_size[g] + 1) begin
                for (int c = 0; c < N; c++) arrived[b][c] = 1'b0;
                m_rsp_valid = 1'b1;
                m_rsp_id = b;
            end
            m_rr = (g + 1) % N;
            p_valid[g] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req_valid = '1;
        #1;
        check_val("ready_in_reset", bus.req_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req_valid = '0;
        model_clear();
    endtask

    task automatic req(input int c, input int id, input int size);
        p_valid[c] = 1'b1;
        p_id[c] = id;
        p_size[c] = size;
    endtask

    task automatic run3(input int n, output int np, output int lid);
        logic [2:0] fired;
        np = 0;
        lid = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus3.rsp_valid === 1'b1) begin
                np++;
                lid = int'(bus3.rsp_id);
            end
            fired = bus3.req_valid & bus3.req_ready;
            @(posedge clk);
            #1;
            bus3.req_valid = bus3.req_valid & ~fired;
        end
    endtask

    initial begin
        int gcount [N];
        int np;
        int lid;
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_id = '0;
        bus.req_size_m1 = '0;
        bus3.req_valid = '0;
        bus3.req_id = '0;
        bus3.req_size_m1 = '0;
        pulses = 0;
        model_clear();
        do_reset();
        cycle();

        // all four cores to id 3, size 4
        for (int c = 0; c < N; c++) req(c, 3, 3);
        for (int k = 0; k < N; k++) begin
            cycle();
            check_val("t1_grant", last_grant, k);
        end
        #2;
        check_val("t1_rsp_valid", bus.rsp_valid, 1);
        check_val("t1_rsp_id", bus.rsp_id, 3);
        cycle();
        cycle();

        // interleaved pairs on ids 1 and 5
        pulses = 0;
        req(0, 1, 1); req(2, 5, 1);
        cycle(); cycle();
        req(1, 1, 1); req(3, 5, 1);
        repeat (4) cycle();
        check_val("t2_pulses", pulses, 2);

        // duplicate arrival does not complete a 2-core barrier
        pulses = 0;
        req(2, 0, 1); cycle(); cycle();
        req(2, 0, 1); cycle(); cycle(); cycle();
        check_val("t3_dup_pulses", pulses, 0);
        req(0, 0, 1); repeat (3) cycle();
        check_val("t3_pulses", pulses, 1);

        // fairness starting from rr_ptr = 2 with all cores continuously requesting
        req(1, 6, 3); cycle();
        for (int c = 0; c < N; c++) gcount[c] = 0;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < N; c++)
                if (!p_valid[c]) req(c, int'($urandom_range(0, B - 1)), int'($urandom_range(0, N - 1)));
            cycle();
            check_val("t4_order", last_grant, (2 + k) % N);
            if (last_grant >= 0) gcount[last_grant]++;
        end
        for (int c = 0; c < N; c++) check_val("t4_fair", gcount[c], 4);
        repeat (N) cycle();

        // reset drops the partial arrival on id 7
        req(1, 7, 1); cycle(); cycle();
        do_reset();
        pulses = 0;
        req(0, 7, 1); repeat (3) cycle();
        check_val("t5_no_rel", pulses, 0);
        #2;
        check_val("t5_busy", bus.busy, 1);
        req(2, 7, 1); repeat (3) cycle();
        check_val("t5_rel", pulses, 1);

        // random traffic, first concentrated on two ids, then spread
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N; c++)
                if (!p_valid[c] && ($urandom_range(0, 1) == 1))
                    req(c, int'($urandom_range(0, (k < 200) ? 1 : B - 1)), int'($urandom_range(0, N - 1)));
            cycle();
        end
        repeat (6) cycle();

        // 3-core instance: size 4 can never be met, other ids still release
        bus3.req_id = {2'd2, 2'd2, 2'd2};
        bus3.req_size_m1 = {2'd3, 2'd3, 2'd3};
        bus3.req_valid = 3'b111;
        run3(8, np, lid);
        check_val("t6_no_rel", np, 0);
        check_val("t6_busy", bus3.busy, 1);
        bus3.req_id = {2'd0, 2'd1, 2'd1};
        bus3.req_size_m1 = {2'd0, 2'd1, 2'd1};
        bus3.req_valid = 3'b011;
        run3(4, np, lid);
        check_val("t6_rel", np, 1);
        check_val("t6_rel_id", lid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
